// File: rtl/constants_pkg.sv
// Default geometry constants for the instruction cache.
package constants_pkg;

  localparam int unsigned ICACHE_ARCH_LEN  = 32;
  localparam int unsigned ICACHE_LINE_BITS = 128;
  localparam int unsigned ICACHE_NUM_LINES = 4;
  localparam int unsigned ICACHE_INST_BITS = 32;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/structure_pkg.sv
// Shared type definitions for the instruction cache.
package structure_pkg;

  typedef enum logic [1:0] {
    IC_READY = 2'd0,
    IC_REQ   = 2'd1,
    IC_WAIT  = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped icache: combinational read,
// single write port, synchronous clear of all valid bits.
module icache_line_array
  import constants_pkg::*;
#(
  parameter int unsigned LINE_BITS  = ICACHE_LINE_BITS,
  parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES,
  parameter int unsigned TAG_BITS   = 26,
  parameter int unsigned INDEX_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_all_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [LINE_BITS-1:0]  wr_line_i,
  input  logic                  wr_set_valid_i
);

  logic [NUM_LINES-1:0] valid_vec;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // Only the valid bits need reset; tag/data are qualified by valid.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    logic valid_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
      end else if (clear_all_i) begin
        valid_q <= 1'b0;
      end else if (wr_en_i && (wr_index_i == INDEX_BITS'(gi))) begin
        valid_q <= wr_set_valid_i;
      end
    end
    assign valid_vec[gi] = valid_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_vec[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line refill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int unsigned ARCH_LEN  = ICACHE_ARCH_LEN,
  parameter int unsigned LINE_BITS = ICACHE_LINE_BITS,
  parameter int unsigned NUM_LINES = ICACHE_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fet_req_valid,
  input  logic [ARCH_LEN-1:0]  fet_req_addr,
  output logic                 fet_rsp_valid,
  output logic [31:0]          fet_rsp_inst,
  output logic                 fet_stall,
  input  logic                 flush,
  output logic                 mem_req_valid,
  output logic [ARCH_LEN-1:0]  mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [LINE_BITS-1:0] mem_rsp_line
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned WORDS       = LINE_BITS / ICACHE_INST_BITS;
  localparam int unsigned WSEL_BITS   = $clog2(WORDS);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS    = ARCH_LEN - OFFSET_BITS - INDEX_BITS;

  icache_state_t         state_q, state_d;
  logic [ARCH_LEN-1:0]   miss_addr_q, miss_addr_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [WSEL_BITS-1:0]  req_wsel;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  unused_addr_lsb;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  lookup_hit;
  logic [31:0]           line_words [WORDS];
  logic                  clear_all;
  logic                  wr_en;
  logic                  wr_set_valid;

  assign req_wsel        = fet_req_addr[OFFSET_BITS-1:2];
  assign req_index       = fet_req_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag         = fet_req_addr[ARCH_LEN-1 -: TAG_BITS];
  assign unused_addr_lsb = ^fet_req_addr[1:0];

  icache_line_array #(
    .LINE_BITS  (LINE_BITS),
    .NUM_LINES  (NUM_LINES),
    .TAG_BITS   (TAG_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_line_array (
    .clk            (clk),
    .rst            (rst),
    .clear_all_i    (clear_all),
    .rd_index_i     (req_index),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_line_o      (rd_line),
    .wr_en_i        (wr_en),
    .wr_index_i     (miss_addr_q[OFFSET_BITS +: INDEX_BITS]),
    .wr_tag_i       (miss_addr_q[ARCH_LEN-1 -: TAG_BITS]),
    .wr_line_i      (mem_rsp_line),
    .wr_set_valid_i (wr_set_valid)
  );

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign line_words[gi] = rd_line[gi*32 +: 32];
  end

  assign lookup_hit   = rd_valid && (rd_tag == req_tag);
  // A flush seen anywhere during the miss (including the fill cycle) keeps the line invalid.
  assign wr_set_valid = !(flush_pend_q || flush);
  assign mem_req_addr = miss_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IC_READY;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    flush_pend_d  = flush_pend_q;
    fet_rsp_valid = 1'b0;
    fet_rsp_inst  = '0;
    fet_stall     = 1'b0;
    mem_req_valid = 1'b0;
    clear_all     = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      IC_READY: begin
        clear_all    = flush;
        flush_pend_d = 1'b0;
        if (fet_req_valid) begin
          if (lookup_hit) begin
            fet_rsp_valid = 1'b1;
            fet_rsp_inst  = line_words[req_wsel];
          end else begin
            fet_stall   = 1'b1;
            miss_addr_d = {fet_req_addr[ARCH_LEN-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            state_d     = IC_REQ;
          end
        end
      end
      IC_REQ: begin
        fet_stall     = 1'b1;
        mem_req_valid = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (mem_req_ready) state_d = IC_WAIT;
      end
      IC_WAIT: begin
        fet_stall = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (mem_rsp_valid) begin
          wr_en        = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = IC_READY;
        end
      end
      default: state_d = IC_READY;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if ((state_q == IC_READY) && fet_req_valid) begin
      if (lookup_hit) hit_count_q  <= sat_inc32(hit_count_q);
      else            miss_count_q <= sat_inc32(miss_count_q);
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed scoreboard bench for icache: fills, hits, conflicts, backpressure,
// flushes, stray responses and reset during a refill.
module tb_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         fet_req_valid;
  logic [31:0]  fet_req_addr;
  logic         fet_rsp_valid;
  logic [31:0]  fet_rsp_inst;
  logic         fet_stall;
  logic         flush;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_line;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [31:0] exp_q [$];

  localparam logic [127:0] L_A = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] L_B = {32'h8, 32'h7, 32'h6, 32'h5};
  localparam logic [127:0] L_C = {32'hC, 32'hB, 32'hA, 32'h9};
  localparam logic [127:0] L_D = {32'h40, 32'h30, 32'h20, 32'h10};

  always #5 clk = ~clk;

  icache dut (
    .clk           (clk),
    .rst           (rst),
    .fet_req_valid (fet_req_valid),
    .fet_req_addr  (fet_req_addr),
    .fet_rsp_valid (fet_rsp_valid),
    .fet_rsp_inst  (fet_rsp_inst),
    .fet_stall     (fet_stall),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_line  (mem_rsp_line)
  );

  always @(posedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) n_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Advance to just after the next rising edge; single-cycle pulses drop here.
  task automatic cyc();
    @(posedge clk);
    #1;
    flush         = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_line  = '0;
  endtask

  task automatic lookup_hit(input logic [31:0] a, input logic [31:0] w);
    cyc();
    fet_req_valid = 1'b1;
    fet_req_addr  = a;
    exp_q.push_back(w);
    #1;
    chk("hit_stall", 32'(fet_stall), 32'd0);
    chk("hit_valid", 32'(fet_rsp_valid), 32'd1);
    if (fet_rsp_valid) chk("hit_inst", fet_rsp_inst, exp_q.pop_front());
    $display("lookup addr=%h rsp_valid=%0d inst=%h exp=%h", a, fet_rsp_valid, fet_rsp_inst, w);
  endtask

  task automatic lookup_miss(input logic [31:0] a);
    cyc();
    fet_req_valid = 1'b1;
    fet_req_addr  = a;
    #1;
    chk("miss_stall", 32'(fet_stall), 32'd1);
    chk("miss_rsp_valid", 32'(fet_rsp_valid), 32'd0);
    chk("miss_req_valid", 32'(mem_req_valid), 32'd0);
    $display("miss addr=%h stall=%0d", a, fet_stall);
  endtask

  // Play memory for the refill started by the preceding miss; ends in the
  // response cycle so the caller's next lookup is the replay cycle.
  task automatic serve(input logic [31:0] line_addr, input logic [127:0] line,
                       input int ready_wait, input bit flush_in_wait);
    int hs0;
    hs0 = n_hs;
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < ready_wait; i++) begin
      #1;
      chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_req_addr", mem_req_addr, line_addr);
      chk("bp_stall", 32'(fet_stall), 32'd1);
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("req_valid", 32'(mem_req_valid), 32'd1);
    chk("req_addr", mem_req_addr, line_addr);
    cyc();
    mem_req_ready = 1'b0;
    #1;
    chk("wait_req_valid", 32'(mem_req_valid), 32'd0);
    chk("wait_stall", 32'(fet_stall), 32'd1);
    if (flush_in_wait) flush = 1'b1;
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = line;
    #1;
    chk("rsp_stall", 32'(fet_stall), 32'd1);
    chk("handshakes", 32'(n_hs - hs0), 32'd1);
    $display("refill addr=%h wait=%0d flush=%0d handshakes=%0d", line_addr, ready_wait,
             flush_in_wait, n_hs - hs0);
  endtask

  initial begin
    rst           = 1'b0;
    fet_req_valid = 1'b0;
    fet_req_addr  = '0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_line  = '0;
    #2;
    chk("rst_rsp_valid", 32'(fet_rsp_valid), 32'd0);
    chk("rst_stall", 32'(fet_stall), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_inst", fet_rsp_inst, 32'd0);
    $display("reset outputs checked");
    cyc();
    rst = 1'b1;

    // Cold miss, replay of a neighbouring word
    lookup_miss(32'h10);
    serve(32'h10, L_A, 0, 1'b0);
    lookup_hit(32'h14, 32'h2);

    // Consecutive hits across the line
    lookup_hit(32'h10, 32'h1);
    lookup_hit(32'h14, 32'h2);
    lookup_hit(32'h18, 32'h3);
    lookup_hit(32'h1C, 32'h4);

    // Conflict on index 1
    lookup_miss(32'h50);
    serve(32'h50, L_B, 0, 1'b0);
    lookup_hit(32'h50, 32'h5);
    lookup_miss(32'h12);
    serve(32'h10, L_A, 0, 1'b0);
    lookup_hit(32'h18, 32'h3);

    // Backpressure on the request channel
    lookup_miss(32'h2C);
    serve(32'h20, L_C, 3, 1'b0);
    lookup_hit(32'h2C, 32'hC);
    lookup_hit(32'h10, 32'h1);

    // Stray response in IC_READY must not disturb anything
    cyc();
    fet_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_line  = L_D;
    #1;
    chk("stray_rsp_valid", 32'(fet_rsp_valid), 32'd0);
    chk("stray_stall", 32'(fet_stall), 32'd0);
    $display("stray response in ready");
    lookup_hit(32'h10, 32'h1);
    lookup_hit(32'h24, 32'hA);

    // Flush during IC_WAIT: fill lands but stays invalid
    lookup_miss(32'h30);
    serve(32'h30, L_D, 0, 1'b1);
    lookup_miss(32'h30);
    serve(32'h30, L_D, 1, 1'b0);
    lookup_hit(32'h34, 32'h20);

    // Flush in IC_READY: same-cycle lookup sees pre-flush state
    cyc();
    fet_req_valid = 1'b1;
    fet_req_addr  = 32'h10;
    flush         = 1'b1;
    exp_q.push_back(32'h1);
    #1;
    chk("flush_hit_valid", 32'(fet_rsp_valid), 32'd1);
    if (fet_rsp_valid) chk("flush_hit_inst", fet_rsp_inst, exp_q.pop_front());
    $display("lookup with flush addr=10 rsp_valid=%0d inst=%h", fet_rsp_valid, fet_rsp_inst);
    lookup_miss(32'h10);
    serve(32'h10, L_A, 0, 1'b0);
    lookup_hit(32'h1C, 32'h4);
    lookup_miss(32'h2C);
    serve(32'h20, L_C, 0, 1'b0);
    lookup_hit(32'h28, 32'hB);

    // Asynchronous reset while in IC_REQ
    lookup_miss(32'h50);
    cyc();
    mem_req_ready = 1'b0;
    #1;
    chk("req_before_rst", 32'(mem_req_valid), 32'd1);
    rst           = 1'b0;
    fet_req_valid = 1'b0;
    #1;
    chk("rst_mid_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mid_stall", 32'(fet_stall), 32'd0);
    chk("rst_mid_req_addr", mem_req_addr, 32'd0);
    $display("reset during request: req_valid=%0d stall=%0d", mem_req_valid, fet_stall);
    cyc();
    rst = 1'b1;
    lookup_miss(32'h10);
    serve(32'h10, L_A, 0, 1'b0);
    lookup_hit(32'h14, 32'h2);

    cyc();
    fet_req_valid = 1'b0;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
